// File: rtl/mat_mac_sched.sv
// -----------------------------------------------------------------------------
// mat_mac_sched
// Arbitrates two requesters for a shared matrix multiply-accumulate datapath
// and sequences it through R = A * B (A is AROW x ACOL, B is ACOL x BCOL).
// One operation is one grant: a load pulse, AROW*BCOL*ACOL MAC cycles with
// idx_k fastest, then idx_j, then idx_i, and finally a one-cycle done pulse.
//
// Build option:
//   MATSCHED_RR_EN defined   -> round-robin arbitration between the requesters
//   MATSCHED_RR_EN undefined -> fixed priority, requester 0 always wins
//
// Ports:
//   clk_i       clock, all state changes on the rising edge
//   rst_i       synchronous active-high reset
//   req_i[1:0]  per-requester request for a full multiply
//   gnt_o[1:0]  one-hot owner of the datapath
//   busy_o      scheduler not idle
//   ld_en_o     one-cycle pulse: latch the owner's operands
//   mac_en_o    acc += A[idx_i][idx_k] * B[idx_k][idx_j]
//   acc_clr_o   clear the accumulator first (idx_k == 0)
//   wr_en_o     write R[idx_i][idx_j] (idx_k == ACOL-1)
//   idx_i_o, idx_j_o, idx_k_o  element indices
//   done_o      one-cycle completion pulse
//   done_id_o   owner of the completing operation, valid with done_o
// -----------------------------------------------------------------------------
module mat_mac_sched #(
   parameter int AROW = 2,
   parameter int ACOL = 2,
   parameter int BCOL = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o,
   output logic       busy_o,
   output logic       ld_en_o,
   output logic       mac_en_o,
   output logic       acc_clr_o,
   output logic       wr_en_o,
   output logic [3:0] idx_i_o,
   output logic [3:0] idx_j_o,
   output logic [3:0] idx_k_o,
   output logic       done_o,
   output logic       done_id_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [3:0] I_MAX = 4'(AROW - 1);
   localparam logic [3:0] J_MAX = 4'(BCOL - 1);
   localparam logic [3:0] K_MAX = 4'(ACOL - 1);

   state_t     state_q, state_d;
   logic [1:0] gnt_q, gnt_d;
   logic       busy_q, busy_d;
   logic       ld_q, ld_d;
   logic       mac_q, mac_d;
   logic       clr_q, clr_d;
   logic       wr_q, wr_d;
   logic [3:0] i_q, i_d;
   logic [3:0] j_q, j_d;
   logic [3:0] k_q, k_d;
   logic       done_q, done_d;
   logic       done_id_q, done_id_d;
   logic       owner_q, owner_d;
   logic       winner;
   logic       last_elem;

`ifdef MATSCHED_RR_EN
   // Requester favoured when both request. Storing "favoured" rather than
   // "last served" lets the register clear to 0 on reset while still meaning
   // that requester 1 was served last.
   logic       prio_q, prio_d;

   // Round-robin winner: a lone requester wins, a tie goes to prio_q.
   always_comb begin
      if (req_i == 2'b11) begin
         winner = prio_q;
      end else begin
         winner = req_i[1];
      end
   end
`else
   // Fixed priority: requester 0 wins whenever it requests.
   always_comb begin
      winner = ~req_i[0];
   end
`endif

   assign last_elem = (i_q == I_MAX) && (j_q == J_MAX) && (k_q == K_MAX);

   // Next-state and next-output logic; outputs are computed one cycle ahead
   // so that every port comes straight from a flop.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      ld_d      = 1'b0;
      mac_d     = 1'b0;
      clr_d     = 1'b0;
      wr_d      = 1'b0;
      i_d       = 4'd0;
      j_d       = 4'd0;
      k_d       = 4'd0;
      done_d    = 1'b0;
      done_id_d = 1'b0;
`ifdef MATSCHED_RR_EN
      prio_d    = prio_q;
`endif
      case (state_q)
         S_IDLE: begin
            gnt_d = 2'b00;
            if (req_i != 2'b00) begin
               state_d = S_LOAD;
               gnt_d   = winner ? 2'b10 : 2'b01;
               owner_d = winner;
               ld_d    = 1'b1;
`ifdef MATSCHED_RR_EN
               prio_d  = ~winner;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            state_d = S_RUN;
            mac_d   = 1'b1;
            clr_d   = 1'b1;
            wr_d    = (K_MAX == 4'd0);
         end
         S_RUN: begin
            if (last_elem) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               done_id_d = owner_q;
            end else begin
               if (k_q == K_MAX) begin
                  k_d = 4'd0;
                  if (j_q == J_MAX) begin
                     j_d = 4'd0;
                     i_d = i_q + 4'd1;
                  end else begin
                     j_d = j_q + 4'd1;
                     i_d = i_q;
                  end
               end else begin
                  k_d = k_q + 4'd1;
                  j_d = j_q;
                  i_d = i_q;
               end
               mac_d = 1'b1;
               clr_d = (k_d == 4'd0);
               wr_d  = (k_d == K_MAX);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            gnt_d   = 2'b00;
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = 2'b00;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         gnt_q     <= 2'b00;
         busy_q    <= 1'b0;
         ld_q      <= 1'b0;
         mac_q     <= 1'b0;
         clr_q     <= 1'b0;
         wr_q      <= 1'b0;
         i_q       <= 4'd0;
         j_q       <= 4'd0;
         k_q       <= 4'd0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         owner_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         ld_q      <= ld_d;
         mac_q     <= mac_d;
         clr_q     <= clr_d;
         wr_q      <= wr_d;
         i_q       <= i_d;
         j_q       <= j_d;
         k_q       <= k_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         owner_q   <= owner_d;
      end
   end

`ifdef MATSCHED_RR_EN
   // Arbitration pointer register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end
`endif

   assign gnt_o     = gnt_q;
   assign busy_o    = busy_q;
   assign ld_en_o   = ld_q;
   assign mac_en_o  = mac_q;
   assign acc_clr_o = clr_q;
   assign wr_en_o   = wr_q;
   assign idx_i_o   = i_q;
   assign idx_j_o   = j_q;
   assign idx_k_o   = k_q;
   assign done_o    = done_q;
   assign done_id_o = done_id_q;

endmodule
